// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: NUM_CH independent pulse-train generators.
// Each channel runs IDLE -> ACTIVE (A cycles high) -> INACTIVE (I cycles low)
// and repeats, either forever (N = 0) or for a burst of N pulses, after which
// it returns to IDLE and strobes done for one cycle.
module pulse_gen_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          enable,
  input  logic [NUM_CH-1:0]          start,
  input  logic [NUM_CH-1:0]          stop,
  input  logic [NUM_CH*CNT_W-1:0]    active_cycles,
  input  logic [NUM_CH*CNT_W-1:0]    inactive_cycles,
  input  logic [NUM_CH*BURST_W-1:0]  burst_len,
  output logic [NUM_CH-1:0]          pulse_out,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH-1:0]          done
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_INACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   ONE_C = CNT_W'(1);
  localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);

  state_t             state_q   [NUM_CH];
  state_t             state_d   [NUM_CH];
  logic [CNT_W-1:0]   ph_cnt_q  [NUM_CH];
  logic [CNT_W-1:0]   ph_cnt_d  [NUM_CH];
  logic [BURST_W-1:0] pls_cnt_q [NUM_CH];
  logic [BURST_W-1:0] pls_cnt_d [NUM_CH];
  logic [CNT_W-1:0]   a_q       [NUM_CH];
  logic [CNT_W-1:0]   a_d       [NUM_CH];
  logic [CNT_W-1:0]   i_q       [NUM_CH];
  logic [CNT_W-1:0]   i_d       [NUM_CH];
  logic [BURST_W-1:0] n_q       [NUM_CH];
  logic [BURST_W-1:0] n_d       [NUM_CH];
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [NUM_CH-1:0]  act_q, act_d;
  logic [NUM_CH-1:0]  busy_q, busy_d;

  logic [CNT_W-1:0]   a_cl [NUM_CH];
  logic [CNT_W-1:0]   i_cl [NUM_CH];
  logic [BURST_W-1:0] n_in [NUM_CH];

  // Unpack per-channel config and clamp zero phase lengths to one cycle.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      a_cl[k] = active_cycles[k*CNT_W +: CNT_W];
      i_cl[k] = inactive_cycles[k*CNT_W +: CNT_W];
      n_in[k] = burst_len[k*BURST_W +: BURST_W];
      if (a_cl[k] == '0) a_cl[k] = ONE_C;
      if (i_cl[k] == '0) i_cl[k] = ONE_C;
    end
  end

  // Per-channel next-state, counter and strobe logic; stop overrides everything.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k]   = state_q[k];
      ph_cnt_d[k]  = ph_cnt_q[k];
      pls_cnt_d[k] = pls_cnt_q[k];
      a_d[k]       = a_q[k];
      i_d[k]       = i_q[k];
      n_d[k]       = n_q[k];
      done_d[k]    = 1'b0;
      if (stop[k]) begin
        state_d[k] = S_IDLE;
      end else begin
        case (state_q[k])
          S_IDLE: begin
            if (start[k]) begin
              a_d[k]       = a_cl[k];
              i_d[k]       = i_cl[k];
              n_d[k]       = n_in[k];
              ph_cnt_d[k]  = a_cl[k] - ONE_C;
              pls_cnt_d[k] = '0;
              state_d[k]   = S_ACTIVE;
            end
          end
          S_ACTIVE: begin
            if (ph_cnt_q[k] == '0) begin
              ph_cnt_d[k] = i_q[k] - ONE_C;
              state_d[k]  = S_INACTIVE;
            end else begin
              ph_cnt_d[k] = ph_cnt_q[k] - ONE_C;
            end
          end
          S_INACTIVE: begin
            if (ph_cnt_q[k] == '0) begin
              // Pulse count is compared before incrementing so it never exceeds N-1.
              if ((n_q[k] != '0) && (pls_cnt_q[k] == (n_q[k] - ONE_B))) begin
                state_d[k] = S_IDLE;
                done_d[k]  = 1'b1;
              end else begin
                if (n_q[k] != '0) pls_cnt_d[k] = pls_cnt_q[k] + ONE_B;
                ph_cnt_d[k] = a_q[k] - ONE_C;
                state_d[k]  = S_ACTIVE;
              end
            end else begin
              ph_cnt_d[k] = ph_cnt_q[k] - ONE_C;
            end
          end
          default: state_d[k] = S_IDLE;
        endcase
      end
      act_d[k]  = (state_d[k] == S_ACTIVE);
      busy_d[k] = (state_d[k] != S_IDLE);
    end
  end

  // State, counters, latched config and registered output decodes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k]   <= S_IDLE;
        ph_cnt_q[k]  <= '0;
        pls_cnt_q[k] <= '0;
        a_q[k]       <= '0;
        i_q[k]       <= '0;
        n_q[k]       <= '0;
      end
      done_q <= '0;
      act_q  <= '0;
      busy_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k]   <= state_d[k];
        ph_cnt_q[k]  <= ph_cnt_d[k];
        pls_cnt_q[k] <= pls_cnt_d[k];
        a_q[k]       <= a_d[k];
        i_q[k]       <= i_d[k];
        n_q[k]       <= n_d[k];
      end
      done_q <= done_d;
      act_q  <= act_d;
      busy_q <= busy_d;
    end
  end

  // Outputs come straight from flops; enable only gates the visible pulse.
  always_comb begin
    pulse_out = enable & act_q;
    busy      = busy_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed testbench for pulse_gen_multi with hand-derived expected waveforms.
module tb_pulse_gen_multi;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_CH-1:0]         enable;
  logic [NUM_CH-1:0]         start;
  logic [NUM_CH-1:0]         stop;
  logic [NUM_CH*CNT_W-1:0]   active_cycles;
  logic [NUM_CH*CNT_W-1:0]   inactive_cycles;
  logic [NUM_CH*BURST_W-1:0] burst_len;
  logic [NUM_CH-1:0]         pulse_out;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         done;

  int vectors     = 0;
  int miscompares = 0;

  pulse_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .start           (start),
    .stop            (stop),
    .active_cycles   (active_cycles),
    .inactive_cycles (inactive_cycles),
    .burst_len       (burst_len),
    .pulse_out       (pulse_out),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge: we are then inside the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int a, input int i, input int n);
    active_cycles[ch*CNT_W +: CNT_W]     = CNT_W'(a);
    inactive_cycles[ch*CNT_W +: CNT_W]   = CNT_W'(i);
    burst_len[ch*BURST_W +: BURST_W]     = BURST_W'(n);
  endtask

  task automatic idle_gap(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  int a3 [4] = '{1, 2, 5, 4};
  int i3 [4] = '{1, 3, 5, 1};

  initial begin
    reset_n = 1'b0;
    enable = '1; start = '0; stop = '0;
    active_cycles = '0; inactive_cycles = '0; burst_len = '0;
    #23;
    chk("reset_out",  32'(pulse_out), 32'h0);
    chk("reset_busy", 32'(busy),      32'h0);
    chk("reset_done", 32'(done),      32'h0);
    reset_n = 1'b1;
    tick();

    // Test 1: ch0 A=3 I=2 N=2.
    set_cfg(0, 3, 2, 2);
    start[0] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      start = '0;
      chk($sformatf("t1_out_c%0d", t),  32'(pulse_out[0]), 32'(((t >= 1 && t <= 3) || (t >= 6 && t <= 8)) ? 1 : 0));
      chk($sformatf("t1_busy_c%0d", t), 32'(busy[0]),      32'((t >= 1 && t <= 10) ? 1 : 0));
      chk($sformatf("t1_done_c%0d", t), 32'(done[0]),      32'((t == 11) ? 1 : 0));
    end
    idle_gap(2);

    // Test 2: ch1 A=1 I=1 continuous, stop at cycle 20.
    set_cfg(1, 1, 1, 0);
    start[1] = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      start = '0;
      stop  = '0;
      if (t <= 20) begin
        chk($sformatf("t2_out_c%0d", t),  32'(pulse_out[1]), 32'(t % 2));
        chk($sformatf("t2_busy_c%0d", t), 32'(busy[1]),      32'h1);
      end else begin
        chk($sformatf("t2_out_c%0d", t),  32'(pulse_out[1]), 32'h0);
        chk($sformatf("t2_busy_c%0d", t), 32'(busy[1]),      32'h0);
      end
      chk($sformatf("t2_done_c%0d", t), 32'(done[1]), 32'h0);
      if (t == 20) stop[1] = 1'b1;
    end
    idle_gap(2);

    // Test 3: four channels, N=3; done at 7, 16, 31, 16.
    for (int k = 0; k < 4; k++) set_cfg(k, a3[k], i3[k], 3);
    start = '1;
    for (int t = 1; t <= 33; t++) begin
      tick();
      start = '0;
      for (int k = 0; k < 4; k++) begin
        int p;
        p = a3[k] + i3[k];
        chk($sformatf("t3_out_k%0d_c%0d", k, t),  32'(pulse_out[k]),
            32'(((t <= 3*p) && (((t-1) % p) < a3[k])) ? 1 : 0));
        chk($sformatf("t3_busy_k%0d_c%0d", k, t), 32'(busy[k]), 32'((t <= 3*p) ? 1 : 0));
        chk($sformatf("t3_done_k%0d_c%0d", k, t), 32'(done[k]), 32'((t == 3*p + 1) ? 1 : 0));
      end
    end
    idle_gap(2);

    // Test 4: ch0 A=4 I=4 continuous, enable low during cycles 10..15.
    set_cfg(0, 4, 4, 0);
    start[0] = 1'b1;
    for (int t = 1; t <= 26; t++) begin
      tick();
      start = '0;
      enable[0] = !(t >= 10 && t <= 15);
      #1;
      chk($sformatf("t4_out_c%0d", t), 32'(pulse_out[0]),
          32'((enable[0] && (((t-1) % 8) < 4)) ? 1 : 0));
      chk($sformatf("t4_busy_c%0d", t), 32'(busy[0]), 32'h1);
    end
    enable = '1;
    stop[0] = 1'b1;
    tick();
    stop = '0;
    chk("t4_stopped_busy", 32'(busy[0]), 32'h0);
    idle_gap(2);

    // Test 5: asynchronous reset in the middle of an active phase.
    set_cfg(0, 10, 2, 0);
    start[0] = 1'b1;
    tick();
    start = '0;
    tick();
    tick();
    chk("t5_pre_out", 32'(pulse_out[0]), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_out",  32'(pulse_out), 32'h0);
    chk("t5_async_busy", 32'(busy),      32'h0);
    #3;
    reset_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk($sformatf("t5_post_out_c%0d", t),  32'(pulse_out), 32'h0);
      chk($sformatf("t5_post_busy_c%0d", t), 32'(busy),      32'h0);
    end

    // Test 6a: A=0 I=0 N=1 on ch2 -> one high, one low, done.
    set_cfg(2, 0, 0, 1);
    start[2] = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      start = '0;
      chk($sformatf("t6a_out_c%0d", t),  32'(pulse_out[2]), 32'((t == 1) ? 1 : 0));
      chk($sformatf("t6a_busy_c%0d", t), 32'(busy[2]),      32'((t <= 2) ? 1 : 0));
      chk($sformatf("t6a_done_c%0d", t), 32'(done[2]),      32'((t == 3) ? 1 : 0));
    end
    idle_gap(2);

    // Test 6b: ch3 A=2 I=2 N=1; a second start with new cfg while busy is ignored.
    set_cfg(3, 2, 2, 1);
    start[3] = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      start = '0;
      if (t == 1) begin
        set_cfg(3, 9, 9, 5);
        start[3] = 1'b1;
      end
      chk($sformatf("t6b_out_c%0d", t),  32'(pulse_out[3]), 32'((t <= 2) ? 1 : 0));
      chk($sformatf("t6b_busy_c%0d", t), 32'(busy[3]),      32'((t <= 4) ? 1 : 0));
      chk($sformatf("t6b_done_c%0d", t), 32'(done[3]),      32'((t == 5) ? 1 : 0));
    end
    idle_gap(2);

    // Test 6c: start and stop together on an idle channel -> stays idle.
    set_cfg(3, 2, 2, 0);
    start[3] = 1'b1;
    stop[3]  = 1'b1;
    tick();
    start = '0;
    stop  = '0;
    chk("t6c_busy", 32'(busy[3]),      32'h0);
    chk("t6c_out",  32'(pulse_out[3]), 32'h0);
    tick();
    chk("t6c_busy2", 32'(busy[3]),     32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
